// File: rtl/multi_ch_disp_pkg.sv
// Shared constants for multi_channel_counter_display: digit/segment widths,
// the hex-to-seven-segment table and a width helper for debounce counters.
package multi_ch_disp_pkg;

  localparam int DIG_W = 4;
  localparam int SEG_W = 7;

  // Active-high segment patterns, bit 6 = A ... bit 0 = G; entry 15 is leftmost.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic logic [SEG_W-1:0] hex_seg(input logic [DIG_W-1:0] digit);
    return SEG_TABLE[digit];
  endfunction

endpackage

// File: rtl/multi_channel_counter_display_switch_debounce.sv
// switch_debounce: two-flop synchroniser followed by a stable-count filter.
// The debounced level only follows the input after DEBOUNCE_CYCLES agreeing samples.
module switch_debounce
  import multi_ch_disp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] stable_cnt;
  logic             level_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], i_Switch};
    end
  end

  // Counter measures how long the synchronised input has disagreed with level_q.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      stable_cnt <= '0;
      level_q    <= 1'b0;
    end else if (sync_q[1] == level_q) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_LAST) begin
      stable_cnt <= '0;
      level_q    <= sync_q[1];
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign o_Switch = level_q;

endmodule

// File: rtl/multi_channel_counter_display.sv
// NUM_CH debounced modulo counters with registered hex seven-segment outputs.
// Define MULTI_CH_DISP_CASCADE_EN to chain channel wraps into a multi-digit counter.
module multi_channel_counter_display
  import multi_ch_disp_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int MODULO          = 10,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SEG_ACTIVE_LOW  = 1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [NUM_CH-1:0]       i_Switch_Inc,
  input  logic [NUM_CH-1:0]       i_Switch_Clr,
  output logic [DIG_W*NUM_CH-1:0] o_Count,
  output logic [SEG_W*NUM_CH-1:0] o_Segment,
  output logic [NUM_CH-1:0]       o_Wrap
);

`ifdef MULTI_CH_DISP_CASCADE_EN
  localparam logic CASCADE_EN = 1'b1;
`else
  localparam logic CASCADE_EN = 1'b0;
`endif

  localparam logic [DIG_W-1:0] LAST_CNT  = DIG_W'(MODULO - 1);
  localparam logic [SEG_W-1:0] SEG_MASK  = (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [SEG_W-1:0] SEG_RESET = SEG_TABLE[0] ^ SEG_MASK;

  logic [NUM_CH-1:0] inc_db;
  logic [NUM_CH-1:0] clr_db;
  logic [NUM_CH-1:0] inc_prev;
  logic [NUM_CH-1:0] inc_evt;
  logic [NUM_CH-1:0] step;
  logic [NUM_CH-1:0] wrap_nxt;
  logic              carry;
  logic [DIG_W-1:0]  cnt_q [NUM_CH];
  logic [SEG_W-1:0]  seg_q [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_sw
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_inc_db (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Switch(i_Switch_Inc[k]),
      .o_Switch(inc_db[k])
    );

    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clr_db (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Switch(i_Switch_Clr[k]),
      .o_Switch(clr_db[k])
    );

    assign o_Count[DIG_W*k +: DIG_W]   = cnt_q[k];
    assign o_Segment[SEG_W*k +: SEG_W] = seg_q[k];
  end

  // One event per press: only the rising edge of the debounced level counts.
  assign inc_evt = inc_db & ~inc_prev;

  // Carry ripples from channel 0 upward within the cycle; a clear kills both
  // the channel's own step and the carry it would pass on.
  always_comb begin
    carry    = 1'b0;
    step     = '0;
    wrap_nxt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      step[k]     = (inc_evt[k] | carry) & ~clr_db[k];
      wrap_nxt[k] = step[k] & (cnt_q[k] == LAST_CNT);
      carry       = CASCADE_EN & wrap_nxt[k];
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      inc_prev <= '0;
      o_Wrap   <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= '0;
        seg_q[k] <= SEG_RESET;
      end
    end else begin
      inc_prev <= inc_db;
      o_Wrap   <= wrap_nxt;
      for (int k = 0; k < NUM_CH; k++) begin
        if (clr_db[k]) begin
          cnt_q[k] <= '0;
        end else if (step[k]) begin
          cnt_q[k] <= wrap_nxt[k] ? '0 : cnt_q[k] + 1'b1;
        end
        // Decoding the registered count makes o_Segment trail o_Count by one cycle.
        seg_q[k] <= hex_seg(cnt_q[k]) ^ SEG_MASK;
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_counter_display.sv
// Self-checking bench for multi_channel_counter_display: directed scenarios plus
// randomized switch activity against a cycle-level behavioural model.
module tb_multi_channel_counter_display;

  localparam int NCH = 2;
  localparam int MOD = 10;
  localparam int DB  = 4;

`ifdef MULTI_CH_DISP_CASCADE_EN
  localparam bit CASC = 1'b1;
`else
  localparam bit CASC = 1'b0;
`endif

  localparam logic [1:0] EXP_CASC_WRAP = CASC ? 2'b11 : 2'b01;
  localparam logic [7:0] EXP_CASC_CNT  = CASC ? 8'h00 : 8'h90;

  // Independent ABCDEFG active-high digit patterns.
  localparam logic [6:0] TB_SEG [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic             clk;
  logic             rst_n;
  logic [NCH-1:0]   inc_raw;
  logic [NCH-1:0]   clr_raw;
  logic [4*NCH-1:0] count;
  logic [7*NCH-1:0] seg;
  logic [NCH-1:0]   wrap;
  logic             inc16;
  logic             clr16;
  logic [3:0]       count16;
  logic [6:0]       seg16;
  logic [0:0]       wrap16;

  int  n_vec;
  int  n_err;
  bit  chk_en;
  int  w0_cnt;
  int  w1_cnt;
  int  w16_cnt;
  logic [3:0] exp_q[$];

  // behavioural model state
  int         m_s1   [2*NCH];
  int         m_s2   [2*NCH];
  int         m_deb  [2*NCH];
  int         m_run  [2*NCH];
  int         m_prev [NCH];
  int         m_cnt  [NCH];
  int         m_wrap [NCH];
  logic [6:0] m_seg  [NCH];

  multi_channel_counter_display #(
    .NUM_CH(NCH), .MODULO(MOD), .DEBOUNCE_CYCLES(DB), .SEG_ACTIVE_LOW(1)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch_Inc(inc_raw), .i_Switch_Clr(clr_raw),
    .o_Count(count), .o_Segment(seg), .o_Wrap(wrap)
  );

  multi_channel_counter_display #(
    .NUM_CH(1), .MODULO(16), .DEBOUNCE_CYCLES(DB), .SEG_ACTIVE_LOW(1)
  ) dut16 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch_Inc(inc16), .i_Switch_Clr(clr16),
    .o_Count(count16), .o_Segment(seg16), .o_Wrap(wrap16)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    return ~TB_SEG[v];
  endfunction

  function automatic int raw_of(input int s);
    return (s < NCH) ? int'(inc_raw[s]) : int'(clr_raw[s-NCH]);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2*NCH; s++) begin
      m_s1[s] = 0; m_s2[s] = 0; m_deb[s] = 0; m_run[s] = 0;
    end
    for (int k = 0; k < NCH; k++) begin
      m_prev[k] = 0; m_cnt[k] = 0; m_wrap[k] = 0; m_seg[k] = seg_of(0);
    end
  endtask

  // One clock of the specified behaviour, using pre-edge values throughout.
  task automatic model_step();
    int carry;
    int ev;
    int bump;
    carry = 0;
    for (int k = 0; k < NCH; k++) begin
      m_seg[k] = seg_of(m_cnt[k]);
      ev   = (m_deb[k] == 1 && m_prev[k] == 0) ? 1 : 0;
      bump = ((ev == 1 || carry == 1) && m_deb[NCH+k] == 0) ? 1 : 0;
      m_wrap[k] = (bump == 1 && m_cnt[k] == MOD-1) ? 1 : 0;
      if (m_deb[NCH+k] == 1) m_cnt[k] = 0;
      else if (bump == 1)    m_cnt[k] = (m_cnt[k] + 1) % MOD;
      carry = CASC ? m_wrap[k] : 0;
      m_prev[k] = m_deb[k];
    end
    for (int s = 0; s < 2*NCH; s++) begin
      if (m_s2[s] != m_deb[s]) begin
        m_run[s]++;
        if (m_run[s] == DB) begin
          m_deb[s] = m_s2[s];
          m_run[s] = 0;
        end
      end else begin
        m_run[s] = 0;
      end
      m_s2[s] = m_s1[s];
      m_s1[s] = raw_of(s);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // scoreboard against the model, sampled away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NCH; k++) begin
        check($sformatf("mdl_cnt%0d", k), count[4*k +: 4], m_cnt[k]);
        check($sformatf("mdl_seg%0d", k), seg[7*k +: 7], m_seg[k]);
        check($sformatf("mdl_wrap%0d", k), wrap[k], m_wrap[k]);
      end
    end
    if (wrap[0]) w0_cnt++;
    if (wrap[1]) w1_cnt++;
    if (wrap16[0]) w16_cnt++;
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int ch, input int hold);
    inc_raw[ch] = 1'b1;
    cycles(hold);
    inc_raw[ch] = 1'b0;
    cycles(DB + 6);
  endtask

  task automatic clear_all();
    clr_raw = '1;
    cycles(DB + 4);
    clr_raw = '0;
    cycles(DB + 6);
  endtask

  initial begin
    int base;
    int found;
    n_vec = 0; n_err = 0; chk_en = 1'b0;
    w0_cnt = 0; w1_cnt = 0; w16_cnt = 0;
    inc_raw = '0; clr_raw = '0; inc16 = 1'b0; clr16 = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    chk_en = 1'b1;
    cycles(2);
    rst_n = 1'b1;

    // reset state
    cycles(1);
    check("rst_count", count, 8'h00);
    check("rst_seg", seg, 14'b0000001_0000001);
    check("rst_wrap", wrap, 2'b00);
    check("rst_count16", count16, 4'h0);
    check("rst_seg16", seg16, 7'b0000001);

    // glitch rejection and exact latency
    inc_raw[0] = 1'b1; cycles(DB - 1); inc_raw[0] = 1'b0; cycles(12);
    check("glitch_cnt", count[3:0], 4'd0);
    inc_raw[0] = 1'b1;
    cycles(DB + 2);
    check("lat_cnt_early", count[3:0], 4'd0);
    cycles(1);
    check("lat_cnt", count[3:0], 4'd1);
    check("lat_seg_early", seg[6:0], 7'b0000001);
    cycles(1);
    check("lat_seg", seg[6:0], 7'b1001111);
    cycles(3);
    inc_raw[0] = 1'b0;
    cycles(DB + 6);

    // ten presses on channel 1: 1..9 then 0 with a single wrap pulse
    clear_all();
    check("clr_cnt", count, 8'h00);
    for (int i = 1; i <= MOD; i++) exp_q.push_back(4'(i % MOD));
    base = w1_cnt;
    while (exp_q.size() > 0) begin
      press(1, DB + 3);
      check("seq_cnt1", count[7:4], exp_q.pop_front());
    end
    check("seq_wrap1", w1_cnt - base, 1);

    // increment and clear debounced together at count 9
    clear_all();
    repeat (MOD - 1) press(0, DB + 3);
    check("cnt9", count[3:0], 4'd9);
    base = w0_cnt;
    inc_raw[0] = 1'b1; clr_raw[0] = 1'b1;
    cycles(12);
    check("simul_cnt", count[3:0], 4'd0);
    check("simul_wrap", w0_cnt - base, 0);
    inc_raw[0] = 1'b0;
    cycles(DB + 6);
    press(0, DB + 4);
    check("clr_hold_cnt", count[3:0], 4'd0);
    clr_raw[0] = 1'b0;
    cycles(DB + 6);

    // cascade (or independence) from 9/9
    clear_all();
    repeat (MOD - 1) begin
      inc_raw = '1; cycles(DB + 3); inc_raw = '0; cycles(DB + 6);
    end
    check("cnt99", count, 8'h99);
    inc_raw[0] = 1'b1;
    found = 0;
    for (int t = 0; t < 20 && found == 0; t++) begin
      cycles(1);
      if (wrap[0]) found = 1;
    end
    check("casc_wrap_seen", found, 1);
    if (found == 1) begin
      check("casc_wrap", wrap, EXP_CASC_WRAP);
      check("casc_cnt", count, EXP_CASC_CNT);
    end
    inc_raw[0] = 1'b0;
    cycles(DB + 6);

    // randomized switch activity, checked every cycle against the model
    for (int it = 0; it < 300; it++) begin
      inc_raw = 2'($urandom_range(0, 3));
      clr_raw = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      cycles($urandom_range(1, 10));
    end
    inc_raw = '0; clr_raw = '0;
    cycles(DB + 8);

    // full hex sweep on the modulo-16 instance
    base = w16_cnt;
    check("sweep_seg0", seg16, seg_of(0));
    for (int v = 1; v <= 16; v++) begin
      inc16 = 1'b1; cycles(DB + 3); inc16 = 1'b0; cycles(DB + 6);
      check("sweep_cnt", count16, v % 16);
      check("sweep_seg", seg16, seg_of(v % 16));
    end
    check("sweep_wrap", w16_cnt - base, 1);

    // reset asserted mid-debounce with a switch held through release
    clear_all();
    press(0, DB + 3);
    inc16 = 1'b1; cycles(DB + 3); inc16 = 1'b0; cycles(DB + 6);
    check("pre_rst_cnt", count[3:0], 4'd1);
    inc_raw[0] = 1'b1; inc16 = 1'b1;
    cycles(3);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_count", count, 8'h00);
    check("mid_rst_seg", seg, 14'b0000001_0000001);
    check("mid_rst_wrap", wrap, 2'b00);
    check("mid_rst_count16", count16, 4'h0);
    check("mid_rst_seg16", seg16, 7'b0000001);
    @(negedge clk);
    cycles(2);
    rst_n = 1'b1;
    cycles(DB + 4);
    check("held_rst_cnt", count[3:0], 4'd1);
    check("held_rst_cnt16", count16, 4'd1);
    inc_raw = '0; inc16 = 1'b0;
    cycles(DB + 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
